// File: rtl/dmem_if.sv
// Data-memory load/store bus between the core's execute/memory stage
// (master) and a memory responder (slave): one request channel and one
// response channel, each with a valid/ready handshake.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory responder. Accepts one load/store at a time,
// spends LATENCY cycles in ACCESS, then holds a single response until the
// initiator takes it. Misaligned, illegal or out-of-range requests skip the
// memory entirely and answer with rsp_err the cycle after acceptance.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // Wide enough to hold LATENCY itself, so the post-commit increment never wraps.
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(LATENCY - 1);
  localparam logic [29:0]   DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_reg, state_next;
  logic          we_reg;
  logic [2:0]    funct_reg;
  logic [AW+1:0] addr_reg;
  logic [31:0]   wdata_reg;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;

  logic          accept;
  logic          req_bad;
  logic          commit;
  logic [AW-1:0] word_idx;
  logic [3:0]    lane_sel;
  logic [31:0]   wr_data;
  logic [31:0]   rd_word;
  logic [7:0]    sel_byte;
  logic [15:0]   sel_half;
  logic [31:0]   load_data;

  assign accept   = bus.req_valid && (state_reg == IDLE);
  assign commit   = (state_reg == ACCESS) && (cnt_reg == CNT_LAST);
  assign word_idx = addr_reg[2 +: AW];

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

  // Classify the incoming request: alignment, funct legality and address range.
  always_comb begin
    req_bad = 1'b0;
    case (bus.req_funct)
      3'b000:  req_bad = 1'b0;
      3'b001:  req_bad = bus.req_addr[0];
      3'b010:  req_bad = |bus.req_addr[1:0];
      3'b100:  req_bad = bus.req_we;
      3'b101:  req_bad = bus.req_we | bus.req_addr[0];
      default: req_bad = 1'b1;
    endcase
    if (bus.req_addr[31:2] >= DEPTH_LIM) begin
      req_bad = 1'b1;
    end
  end

  // State register; reset aborts whatever transaction is in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode: errors bypass ACCESS, responses wait for rsp_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.req_valid) state_next = req_bad ? RESP : ACCESS;
      ACCESS:  if (commit) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture, latency counter and registered response fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_reg    <= 1'b0;
      funct_reg <= 3'b000;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        we_reg    <= bus.req_we;
        funct_reg <= bus.req_funct;
        addr_reg  <= bus.req_addr[AW+1:0];
        wdata_reg <= bus.req_wdata;
        cnt_reg   <= '0;
      end else if (state_reg == ACCESS) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      if (accept && req_bad) begin
        err_reg   <= 1'b1;
        rdata_reg <= '0;
      end else if (commit) begin
        err_reg   <= 1'b0;
        rdata_reg <= we_reg ? 32'h0 : load_data;
      end else if ((state_reg == RESP) && bus.rsp_ready) begin
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end
    end
  end

  // Store lane enables and lane-replicated write data; only B/H/W reach here for stores.
  always_comb begin
    lane_sel = 4'b1111;
    wr_data  = wdata_reg;
    case (funct_reg[1:0])
      2'b00: begin
        lane_sel = 4'b0001 << addr_reg[1:0];
        wr_data  = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        lane_sel = addr_reg[1] ? 4'b1100 : 4'b0011;
        wr_data  = {2{wdata_reg[15:0]}};
      end
      default: begin
        lane_sel = 4'b1111;
        wr_data  = wdata_reg;
      end
    endcase
  end

  // One byte-wide RAM per lane so partial stores need no read-modify-write.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      // Lane write at the commit edge; contents are intentionally never reset.
      always_ff @(posedge clk) begin
        if (commit && we_reg && lane_sel[gi]) begin
          lane_mem[word_idx] <= wr_data[gi*8 +: 8];
        end
      end

      assign rd_word[gi*8 +: 8] = lane_mem[word_idx];
    end
  endgenerate

  // Pick the addressed byte/half and extend it; the result is registered at commit.
  always_comb begin
    sel_byte = rd_word[7:0];
    case (addr_reg[1:0])
      2'b00:   sel_byte = rd_word[7:0];
      2'b01:   sel_byte = rd_word[15:8];
      2'b10:   sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    sel_half = addr_reg[1] ? rd_word[31:16] : rd_word[15:0];
    case (funct_reg)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = rd_word;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a table of load/store vectors with expected
// responses pushed to a scoreboard queue at acceptance and popped when the
// response appears, plus hand-written backpressure and reset sequences.
module tb_dmem_responder;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset;
  dmem_if bus ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  funct;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  logic [32:0] exp_q [$];
  vec_t        vecs [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic we, input logic [2:0] f, input logic [31:0] a,
                             input logic [31:0] d, input logic [31:0] r, input logic e);
    vec_t t;
    t.we = we; t.funct = f; t.addr = a; t.wdata = d; t.rdata = r; t.err = e;
    return t;
  endfunction

  // Present a request in IDLE, record its expected response at the accept edge,
  // then scramble the request fields to show they are not sampled again.
  task automatic drive_req(input logic we, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [31:0] er, input logic ee);
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_funct = f;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(posedge clk);
    exp_q.push_back({ee, er});
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  // Wait (bounded) for rsp_valid, check the latency and pop the scoreboard.
  task automatic wait_rsp(input int exp_lat, input string name);
    int          n;
    logic [32:0] e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rsp_valid && n < 20);
    check({name, "_latency"}, 32'(n), 32'(exp_lat));
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 33'h1_5555_5555;
    check({name, "_rdata"}, bus.rsp_rdata, e[31:0]);
    check({name, "_err"}, 32'(bus.rsp_err), 32'(e[32]));
  endtask

  // With rsp_ready high the response lasts one cycle and IDLE follows.
  task automatic finish_rsp(input string name);
    @(negedge clk);
    check({name, "_rsp_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
    check({name, "_req_ready_back"}, 32'(bus.req_ready), 32'd1);
    check({name, "_rdata_clr"}, bus.rsp_rdata, 32'd0);
    check({name, "_err_clr"}, 32'(bus.rsp_err), 32'd0);
  endtask

  task automatic txn(input vec_t t, input string name);
    bus.rsp_ready = 1'b1;
    drive_req(t.we, t.funct, t.addr, t.wdata, t.rdata, t.err);
    wait_rsp(t.err ? 1 : LAT + 1, name);
    $display("[TB] txn %s we=%0b f=%03b addr=0x%08h wdata=0x%08h -> rdata=0x%08h err=%0b",
             name, t.we, t.funct, t.addr, t.wdata, bus.rsp_rdata, bus.rsp_err);
    finish_rsp(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_funct = 3'b000;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;

    // Reset held for three cycles, then released.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("idle_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("idle_rsp_err", 32'(bus.rsp_err), 32'd0);

    vecs[0]  = v(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0);
    vecs[1]  = v(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    vecs[2]  = v(1, 3'b010, 32'h20, 32'h0, 32'h0, 0);
    vecs[3]  = v(1, 3'b000, 32'h23, 32'h000000F0, 32'h0, 0);
    vecs[4]  = v(0, 3'b010, 32'h20, 32'h0, 32'hF0000000, 0);
    vecs[5]  = v(0, 3'b000, 32'h23, 32'h0, 32'hFFFFFFF0, 0);
    vecs[6]  = v(0, 3'b100, 32'h23, 32'h0, 32'h000000F0, 0);
    vecs[7]  = v(1, 3'b001, 32'h22, 32'h00008001, 32'h0, 0);
    vecs[8]  = v(0, 3'b001, 32'h22, 32'h0, 32'hFFFF8001, 0);
    vecs[9]  = v(0, 3'b101, 32'h22, 32'h0, 32'h00008001, 0);
    vecs[10] = v(0, 3'b010, 32'h20, 32'h0, 32'h80010000, 0);
    vecs[11] = v(1, 3'b000, 32'h21, 32'h0000005A, 32'h0, 0);
    vecs[12] = v(0, 3'b010, 32'h20, 32'h0, 32'h80015A00, 0);
    vecs[13] = v(0, 3'b010, 32'h11, 32'h0, 32'h0, 1);
    vecs[14] = v(0, 3'b001, 32'h13, 32'h0, 32'h0, 1);
    vecs[15] = v(1, 3'b100, 32'h40, 32'h000000FF, 32'h0, 1);
    vecs[16] = v(0, 3'b010, 32'(DEPTH * 4), 32'h0, 32'h0, 1);
    vecs[17] = v(1, 3'b010, 32'h12, 32'hFFFFFFFF, 32'h0, 1);
    vecs[18] = v(0, 3'b011, 32'h10, 32'h0, 32'h0, 1);
    vecs[19] = v(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0);
    vecs[20] = v(0, 3'b000, 32'h11, 32'h0, 32'hFFFFFFBE, 0);
    vecs[21] = v(0, 3'b101, 32'h12, 32'h0, 32'h0000DEAD, 0);
    vecs[22] = v(1, 3'b001, 32'h21, 32'h00001111, 32'h0, 1);
    vecs[23] = v(0, 3'b010, 32'h20, 32'h0, 32'h80015A00, 0);

    for (int i = 0; i < 24; i++) begin
      txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: response held for several cycles, a stray request ignored.
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    wait_rsp(LAT + 1, "bp");
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_funct = 3'b010;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0;
      end else begin
        bus.req_valid = 1'b0;
      end
      @(negedge clk);
      check("bp_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
      check("bp_rdata_stable", bus.rsp_rdata, 32'hDEADBEEF);
      check("bp_req_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    finish_rsp("bp");
    txn(v(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0), "bp_after");

    // Asynchronous reset mid-cycle while a response is held.
    bus.rsp_ready = 1'b0;
    drive_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h80015A00, 1'b0);
    wait_rsp(LAT + 1, "arst");
    #2 reset = 1'b0;
    #1;
    check("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("arst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("arst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("arst_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.rsp_ready = 1'b1;

    // Reset during ACCESS must abort a store before its commit edge.
    txn(v(1, 3'b010, 32'h30, 32'hAAAAAAAA, 32'h0, 0), "abort_init");
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_funct = 3'b010;
    bus.req_addr  = 32'h30;
    bus.req_wdata = 32'h12345678;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_access", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_req_ready", 32'(bus.req_ready), 32'd1);
    txn(v(0, 3'b010, 32'h30, 32'h0, 32'hAAAAAAAA, 0), "abort_check");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the data-memory load/store interface issued by the core's execute/memory stage. It accepts one request at a time through a valid/ready handshake and models a word-organised data memory with configurable access latency. It performs RISC-V byte/half/word stores with lane merging, and sign- or zero-extended loads. It returns one response per request, with an error flag for misaligned, illegal or out-of-range accesses.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; power of two, >= 4
- LATENCY, 2, cycles spent in ACCESS state; integer >= 1
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low byte/half used for B/H
- rsp_valid  out  1  response present; held until accepted
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected; memory not modified

## Operation
- FSM states are IDLE, ACCESS and RESP. req_ready = (state == IDLE), decoded combinationally from state.
- Accept: req_valid & req_ready at a rising edge. On accept, latch we, funct, addr and wdata, and check the request:
  - misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0
  - illegal funct: 011, 110 or 111; also 100/101 with we=1
  - out of range: addr[31:2] >= DEPTH_WORDS
- Error on accept: go to RESP directly with rsp_err=1 and rsp_rdata=0. No memory access is made.
- Otherwise go to ACCESS with latency counter = 0. The counter increments each cycle. When counter == LATENCY-1, at that edge:
  - Store: write the selected byte lanes of word addr[2 +: log2(DEPTH_WORDS)]. Lanes are B: addr[1:0]; H: addr[1]*2 and +1; W: all four. Register rsp_rdata=0.
  - Load: select the byte/half by addr[1:0]. Sign-extend for B/H, zero-extend for BU/HU. Register the result into rsp_rdata.
  - Go to RESP with rsp_err=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready=1 at an edge, then return to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
- req_valid in ACCESS or RESP is ignored (req_ready=0). The request is not queued.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset (reset=0, asynchronous) sets state to IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0 and counter=0. req_ready=1 while in reset and after.
- Reset asserted mid-operation aborts the transaction. A store whose commit edge has not occurred never writes.
- For a valid request accepted at edge E, the write commits at edge E+LATENCY and rsp_valid is first high in the cycle after E+LATENCY.
- For an error request accepted at edge E, rsp_valid is first high in the cycle after E.
- When rsp_ready=1 during the first RESP cycle, the response lasts exactly 1 cycle. The cycle after it is IDLE (req_ready=1), so back-to-back throughput is 1 request per LATENCY+2 cycles.
- rsp_valid never drops without rsp_ready. No combinational path from req_* inputs to rsp_* outputs.
- req_* inputs are sampled only at the accept edge. Later changes have no effect.

## Test plan
- Reset then idle: hold reset=0 for 3 cycles, release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. Assert reset asynchronously mid-cycle -> outputs clear without waiting for clk.
- Word round trip, LATENCY=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_rdata=0xDEADBEEF with rsp_err=0. rsp_valid is high in the 3rd cycle after each accept edge.
- Lane merge and extension, after SW 0x20 = 0x00000000:
  - SB 0x23 data 0x000000F0, then LW 0x20 -> 0xF0000000
  - LB 0x23 -> 0xFFFFFFF0; LBU 0x23 -> 0x000000F0
  - SH 0x22 data 0x8001, then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001
- Errors: LW 0x11, LH 0x13, SB with funct 100, and LW at DEPTH_WORDS*4 -> each gives rsp_err=1 and rsp_rdata=0 the cycle after accept. A following LW 0x10 still returns 0xDEADBEEF.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load response -> rsp_valid stays 1, data is stable and req_ready stays 0. A req_valid pulse during this window is not accepted. Set rsp_ready=1 -> IDLE on the next cycle.
- Reset abort: accept SW 0x30 = 0x12345678 over old value 0xAAAAAAAA and assert reset during ACCESS before the commit edge -> after reset, LW 0x30 returns 0xAAAAAAAA.
